imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl.sv | 164 ++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: receives a length-prefixed byte stream, assembles
// little-endian 32-bit words, writes them into instruction memory, then
// releases the core. Failed loads park in ERR until reset.
//
// Byte-stream handshake: a byte transfers on every CLK edge where rx_valid
// and rx_ready are both 1. rx_ready depends only on the registered state, so
// a producer may hold rx_valid/rx_data until it sees the transfer edge.
module imem_boot_ctrl #(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              boot_skip,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_err
);

  localparam int CW = ADDR_W + 1;              // word counter reaches 2^ADDR_W without wrapping
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              accept;
  logic [15:0]       len_full;

  // Handshake and status outputs are decoded from the registered state only
  assign rx_ready  = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_DATA);
  assign core_run  = (state_q == S_RUN);
  assign load_err  = (state_q == S_ERR);
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_q[7:0]};

  // Next-state, counters, word assembly and write-port staging
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    buf_d       = buf_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        // boot_skip wins; a byte accepted in the same cycle is simply dropped
        if (boot_skip) begin
          state_d = S_RUN;
        end else if (accept) begin
          len_d   = {8'h00, rx_data};
          tmo_d   = '0;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (accept) begin
          len_d = len_full;
          if ((len_full == 16'd0) || (32'(len_full) > (32'd1 << ADDR_W))) begin
            state_d = S_ERR;
          end else begin
            word_cnt_d = '0;
            byte_cnt_d = '0;
            buf_d      = '0;
            tmo_d      = '0;
            state_d    = S_DATA;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DATA: begin
        if (accept) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          case (byte_cnt_q)
            2'd0:    buf_d[7:0]   = rx_data;
            2'd1:    buf_d[15:8]  = rx_data;
            2'd2:    buf_d[23:16] = rx_data;
            default: buf_d[31:24] = rx_data;
          endcase
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = {rx_data, buf_q[23:0]};
            word_cnt_d  = word_cnt_q + 1'b1;
            if ((32'(word_cnt_q) + 32'd1) == 32'(len_q)) begin
              state_d = S_FLUSH;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // Final write strobe is on the bus during this state
      S_FLUSH: state_d = S_RUN;

      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      buf_q       <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      buf_q       <= buf_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: loads built from word lists, expected writes
// queued as bytes are issued, a monitor retiring them on every mem_we.
module tb_imem_boot_ctrl;

  localparam int ADDR_W  = 13;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              boot_skip = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              load_err;

  int checks  = 0;
  int passed  = 0;
  int wr_seen = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        words[$];
  logic [ADDR_W+31:0] mon_e;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .boot_skip(boot_skip),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .core_run (core_run),
    .load_err (load_err)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe retires the oldest expected write
  always @(negedge CLK) begin
    if (!RST && mem_we) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_waddr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(mem_waddr), 64'(mon_e[ADDR_W+31:32]));
        check("write_data", 64'(mem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Driver: idle for gap cycles, then offer one byte until it transfers
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bit   ok;
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      acc = rx_ready;
      @(negedge CLK);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL byte_accept: got no transfer of 0x%0h expected transfer", b);
    end
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    boot_skip = 1'b0;
    rx_valid  = 1'b0;
    @(negedge CLK);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_waddr", 64'(mem_waddr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_core_run",  64'(core_run),  64'd0);
    check("rst_load_err",  64'(load_err),  64'd0);
    check("rst_rx_ready",  64'(rx_ready),  64'd1);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Full load of the words list; slow_byte gets slow_gap idle cycles before it
  task automatic run_load(input bit rnd, input int slow_byte, input int slow_gap);
    int n;
    int w0;
    int g;
    n  = words.size();
    w0 = wr_seen;
    send_byte(n[7:0], 0);
    send_byte(n[15:8], rnd ? rgap() : 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        g = rnd ? rgap() : 0;
        if (4 * i + k == slow_byte) g = slow_gap;
        if (k == 3) exp_q.push_back({ADDR_W'(i), words[i]});
        send_byte(words[i][8*k +: 8], g);
      end
    end
    check("flush_we",       64'(mem_we),   64'd1);
    check("flush_core_run", 64'(core_run), 64'd0);
    check("flush_rx_ready", 64'(rx_ready), 64'd0);
    @(negedge CLK);
    check("run_core_run",  64'(core_run), 64'd1);
    check("run_we",        64'(mem_we),   64'd0);
    check("run_load_err",  64'(load_err), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("write_count",   64'(wr_seen - w0), 64'(n));
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_load_err"}, 64'(load_err), 64'd1);
    check({tag, "_core_run"}, 64'(core_run), 64'd0);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
  endtask

  initial begin
    int w0;

    // Two-word reference load, then rx_valid must be ignored in RUN
    do_reset();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    run_load(1'b0, -1, 0);
    w0 = wr_seen;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (5) @(negedge CLK);
    rx_valid = 1'b0;
    check("run_holds",        64'(core_run), 64'd1);
    check("run_no_write",     64'(wr_seen - w0), 64'd0);

    // boot_skip straight to RUN
    do_reset();
    w0 = wr_seen;
    boot_skip = 1'b1;
    @(negedge CLK);
    boot_skip = 1'b0;
    check("skip_core_run", 64'(core_run), 64'd1);
    check("skip_rx_ready", 64'(rx_ready), 64'd0);
    check("skip_load_err", 64'(load_err), 64'd0);
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom());
      @(negedge CLK);
    end
    rx_valid = 1'b0;
    check("skip_no_write", 64'(wr_seen - w0), 64'd0);
    check("skip_holds",    64'(core_run), 64'd1);

    // Zero length and oversize length both fail
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    expect_err("len0");
    repeat (4) @(negedge CLK);
    expect_err("len0_sticky");
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    expect_err("len8193");

    // Inter-byte gap of TIMEOUT-1 idle cycles is tolerated
    do_reset();
    fill_words(1);
    run_load(1'b0, 1, TIMEOUT - 1);

    // Gap of TIMEOUT idle cycles aborts without a write
    do_reset();
    w0 = wr_seen;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    repeat (TIMEOUT - 1) @(negedge CLK);
    check("tmo_not_yet", 64'(load_err), 64'd0);
    @(negedge CLK);
    expect_err("tmo");
    check("tmo_no_write", 64'(wr_seen - w0), 64'd0);

    // Reset mid-load leaves exactly the completed word written
    do_reset();
    fill_words(2);
    w0 = wr_seen;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 6; b++) begin
      if (b == 3) exp_q.push_back({ADDR_W'(0), words[0]});
      send_byte(words[b / 4][8*(b % 4) +: 8], 0);
    end
    do_reset();
    check("abort_writes", 64'(wr_seen - w0), 64'd1);
    check("abort_queue",  64'(exp_q.size()), 64'd0);
    fill_words(1);
    run_load(1'b0, -1, 0);

    // Random short loads with random idle gaps
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fill_words($urandom_range(1, 20));
      run_load(1'b1, -1, 0);
    end

    // Maximum-length load: 2^ADDR_W words ending at the top address
    do_reset();
    fill_words(1 << ADDR_W);
    run_load(1'b1, -1, 0);
    check("max_final_addr", 64'(mem_waddr), 64'((1 << ADDR_W) - 1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
